// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM for the 24-bit CPU.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the
// datapath enables for the current step. It waits on MemReady in FETCH and
// MEM, flags unknown opcodes, holds in FETCH on Halt and keeps a saturating
// count of retired instructions.
module multicycle_control_unit #(
  parameter int OPCODE_WIDTH = 4,
  parameter int ALUOP_WIDTH  = 2,
  parameter int CNT_WIDTH    = 16,
  parameter logic [OPCODE_WIDTH-1:0] OP_RTYPE = 4'b0110,
  parameter logic [OPCODE_WIDTH-1:0] OP_MUL   = 4'b0111,
  parameter logic [OPCODE_WIDTH-1:0] OP_LW    = 4'b0010,
  parameter logic [OPCODE_WIDTH-1:0] OP_SW    = 4'b0011,
  parameter logic [OPCODE_WIDTH-1:0] OP_BEQ   = 4'b0100,
  parameter logic [OPCODE_WIDTH-1:0] OP_ADDI  = 4'b0001
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic [OPCODE_WIDTH-1:0] OPCODE,
  input  logic                    MemReady,
  input  logic                    Halt,
  output logic                    IRWrite,
  output logic                    PCWrite,
  output logic                    PCWriteCond,
  output logic                    IorD,
  output logic                    MemRead,
  output logic                    MemWrite,
  output logic                    MemToReg,
  output logic                    RegDst,
  output logic                    RegWrite,
  output logic                    AluSrcA,
  output logic [1:0]              AluSrcB,
  output logic [ALUOP_WIDTH-1:0]  AluOp,
  output logic [2:0]              State,
  output logic                    IllegalOp,
  output logic                    InstrDone,
  output logic [CNT_WIDTH-1:0]    RetiredCount
);

  typedef enum logic [2:0] {
    sFetch  = 3'd0,
    sDecode = 3'd1,
    sExec   = 3'd2,
    sMem    = 3'd3,
    sWb     = 3'd4
  } state_t;

  state_t                  stateReg;
  logic [OPCODE_WIDTH-1:0] opReg;
  logic [CNT_WIDTH-1:0]    countReg;
  logic                    opLegal;

  // Opcode currently on the instruction register is one we know how to run.
  always_comb begin
    opLegal = (OPCODE == OP_RTYPE) || (OPCODE == OP_MUL) || (OPCODE == OP_LW) ||
              (OPCODE == OP_SW)    || (OPCODE == OP_BEQ) || (OPCODE == OP_ADDI);
  end

  // State sequencing, opcode latch and saturating retire counter.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      stateReg <= sFetch;
      opReg    <= '0;
      countReg <= '0;
    end else begin
      case (stateReg)
        sFetch: begin
          if (!Halt && MemReady) stateReg <= sDecode;
        end
        sDecode: begin
          opReg    <= OPCODE;
          stateReg <= opLegal ? sExec : sFetch;
        end
        sExec: begin
          if (opReg == OP_LW || opReg == OP_SW)
            stateReg <= sMem;
          else if (opReg == OP_RTYPE || opReg == OP_MUL || opReg == OP_ADDI)
            stateReg <= sWb;
          else
            stateReg <= sFetch;
        end
        sMem: begin
          if (MemReady) stateReg <= (opReg == OP_LW) ? sWb : sFetch;
        end
        default: stateReg <= sFetch;
      endcase
      if (InstrDone && (countReg != '1)) countReg <= countReg + 1'b1;
    end
  end

  // Per-state datapath controls; everything is held low while Reset is high
  // so an aborted instruction cannot touch memory, the PC or the registers.
  always_comb begin
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemToReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    AluSrcA     = 1'b0;
    AluSrcB     = 2'b00;
    AluOp       = '0;
    IllegalOp   = 1'b0;
    InstrDone   = 1'b0;
    if (!Reset) begin
      case (stateReg)
        sFetch: begin
          if (!Halt) begin
            MemRead = 1'b1;
            AluSrcB = 2'b01;
            IRWrite = MemReady;
            PCWrite = MemReady;
          end
        end
        sDecode: begin
          AluSrcB   = 2'b11;
          IllegalOp = !opLegal;
        end
        sExec: begin
          AluSrcA = 1'b1;
          if (opReg == OP_RTYPE) begin
            AluOp = ALUOP_WIDTH'(2'b10);
          end else if (opReg == OP_MUL) begin
            AluOp = ALUOP_WIDTH'(2'b11);
          end else if (opReg == OP_LW || opReg == OP_SW || opReg == OP_ADDI) begin
            AluSrcB = 2'b10;
          end else if (opReg == OP_BEQ) begin
            AluOp       = ALUOP_WIDTH'(2'b01);
            PCWriteCond = 1'b1;
            InstrDone   = 1'b1;
          end
        end
        sMem: begin
          IorD      = 1'b1;
          MemRead   = (opReg == OP_LW);
          MemWrite  = (opReg == OP_SW);
          InstrDone = (opReg == OP_SW) && MemReady;
        end
        sWb: begin
          RegWrite  = 1'b1;
          InstrDone = 1'b1;
          RegDst    = (opReg == OP_RTYPE) || (opReg == OP_MUL);
          MemToReg  = (opReg == OP_LW);
        end
        default: ;
      endcase
    end
  end

  assign State        = stateReg;
  assign RetiredCount = countReg;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: directed scenarios plus a
// randomized instruction stream checked against a per-instruction trace model.
module tb_multicycle_control_unit;

  localparam int CW   = 3;
  localparam int CMAX = (1 << CW) - 1;

  logic          Clock = 1'b0;
  logic          Reset;
  logic [3:0]    OPCODE;
  logic          MemReady;
  logic          Halt;
  logic          IRWrite, PCWrite, PCWriteCond, IorD, MemRead, MemWrite;
  logic          MemToReg, RegDst, RegWrite, AluSrcA;
  logic [1:0]    AluSrcB;
  logic [1:0]    AluOp;
  logic [2:0]    State;
  logic          IllegalOp, InstrDone;
  logic [CW-1:0] RetiredCount;

  multicycle_control_unit #(.CNT_WIDTH(CW)) dut (
    .Clock(Clock), .Reset(Reset), .OPCODE(OPCODE), .MemReady(MemReady), .Halt(Halt),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemToReg(MemToReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .AluSrcA(AluSrcA), .AluSrcB(AluSrcB), .AluOp(AluOp),
    .State(State), .IllegalOp(IllegalOp), .InstrDone(InstrDone),
    .RetiredCount(RetiredCount)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic irw, pcw, pcc, iord, mr, mw, m2r, rd, rw, asa;
    logic [1:0] asb;
    logic [1:0] aop;
    logic ill, done;
  } ctl_t;

  int total = 0;
  int bad = 0;
  int cntModel = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic ctl_t observed();
    observed = {IRWrite, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemToReg,
                RegDst, RegWrite, AluSrcA, AluSrcB, AluOp, IllegalOp, InstrDone};
  endfunction

  function automatic logic isLegal(input logic [3:0] op);
    return op inside {4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0110, 4'b0111};
  endfunction

  function automatic logic r1();
    return 1'($urandom);
  endfunction

  function automatic logic [3:0] r4();
    return 4'($urandom);
  endfunction

  // One clock cycle: drive inputs just after the edge, compare on the falling edge.
  task automatic cycle(input ctl_t exp, input logic [2:0] st, input logic mr,
                       input logic hl, input logic [3:0] op);
    MemReady = mr;
    Halt     = hl;
    OPCODE   = op;
    @(negedge Clock);
    chk("state", 32'(State), 32'(st));
    chk("ctl", 32'(observed()), 32'(exp));
    chk("count", 32'(RetiredCount), 32'(cntModel));
    @(posedge Clock);
    if (exp.done && cntModel < CMAX) cntModel++;
    #1;
  endtask

  // Expected cycle-by-cycle behaviour of one instruction, derived from the
  // opcode class: h halted cycles, fw fetch stalls, mw memory stalls.
  task automatic runInstr(input logic [3:0] op, input int fw, input int mw,
                          input int h, output int n);
    ctl_t c;
    n = 0;
    c = '0;
    repeat (h) begin cycle(c, 3'd0, r1(), 1'b1, r4()); n++; end
    c = '0; c.mr = 1'b1; c.asb = 2'b01;
    repeat (fw) begin cycle(c, 3'd0, 1'b0, 1'b0, r4()); n++; end
    c.irw = 1'b1; c.pcw = 1'b1;
    cycle(c, 3'd0, 1'b1, 1'b0, r4()); n++;
    c = '0; c.asb = 2'b11; c.ill = !isLegal(op);
    cycle(c, 3'd1, r1(), r1(), op); n++;
    if (isLegal(op)) begin
      c = '0; c.asa = 1'b1;
      case (op)
        4'b0110: c.aop = 2'b10;
        4'b0111: c.aop = 2'b11;
        4'b0100: begin c.aop = 2'b01; c.pcc = 1'b1; c.done = 1'b1; end
        default: c.asb = 2'b10;
      endcase
      cycle(c, 3'd2, r1(), r1(), r4()); n++;
      if (op == 4'b0010 || op == 4'b0011) begin
        c = '0; c.iord = 1'b1;
        if (op == 4'b0010) c.mr = 1'b1; else c.mw = 1'b1;
        repeat (mw) begin cycle(c, 3'd3, 1'b0, r1(), r4()); n++; end
        c.done = (op == 4'b0011);
        cycle(c, 3'd3, 1'b1, r1(), r4()); n++;
      end
      if (op != 4'b0100 && op != 4'b0011) begin
        c = '0; c.rw = 1'b1; c.done = 1'b1;
        c.rd  = (op == 4'b0110 || op == 4'b0111);
        c.m2r = (op == 4'b0010);
        cycle(c, 3'd4, r1(), r1(), r4()); n++;
      end
    end
    $display("instr op=%b fw=%0d mw=%0d halt=%0d cycles=%0d retired=%0d",
             op, fw, mw, h, n, RetiredCount);
  endtask

  task automatic doReset();
    Reset = 1'b1;
    #1;
    chk("rst_state", 32'(State), 32'd0);
    chk("rst_count", 32'(RetiredCount), 32'd0);
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    cntModel = 0;
    $display("reset applied");
  endtask

  localparam logic [3:0] SEQ_OPS [6] = '{4'b0110, 4'b0010, 4'b0011, 4'b0100, 4'b0001, 4'b0111};
  localparam int         SEQ_LAT [6] = '{4, 5, 4, 3, 4, 4};
  localparam logic [3:0] LEGAL   [6] = '{4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0110, 4'b0111};

  initial begin
    int n;
    ctl_t c;
    logic [3:0] op;
    Reset = 1'b1; MemReady = 1'b0; Halt = 1'b0; OPCODE = 4'd0;
    @(negedge Clock);
    chk("init_state", 32'(State), 32'd0);
    chk("init_mr", 32'(MemRead), 32'd0);
    chk("init_count", 32'(RetiredCount), 32'd0);
    @(posedge Clock);
    #1;
    Reset = 1'b0;

    // Back-to-back mix with memory always ready.
    for (int i = 0; i < 6; i++) begin
      runInstr(SEQ_OPS[i], 0, 0, 0, n);
      chk("latency", 32'(n), 32'(SEQ_LAT[i]));
    end
    chk("count6", 32'(RetiredCount), 32'd6);

    // Load with fetch and memory stalls.
    doReset();
    runInstr(4'b0010, 3, 2, 0, n);
    chk("lw_stall_lat", 32'(n), 32'd10);
    chk("lw_count", 32'(RetiredCount), 32'd1);

    // Illegal opcode aborts without retiring.
    runInstr(4'b1111, 0, 0, 0, n);
    chk("ill_lat", 32'(n), 32'd2);
    chk("ill_count", 32'(RetiredCount), 32'd1);

    // Halt held five cycles, then a branch.
    runInstr(4'b0100, 0, 0, 5, n);
    chk("halt_lat", 32'(n), 32'd8);

    // Saturation of the narrow counter.
    doReset();
    for (int i = 0; i < 9; i++) runInstr(4'b0100, 0, 0, 0, n);
    chk("saturate", 32'(RetiredCount), 32'd7);

    // Reset in the middle of a load's memory phase.
    doReset();
    c = '0; c.mr = 1'b1; c.asb = 2'b01; c.irw = 1'b1; c.pcw = 1'b1;
    cycle(c, 3'd0, 1'b1, 1'b0, 4'd0);
    c = '0; c.asb = 2'b11;
    cycle(c, 3'd1, 1'b1, 1'b0, 4'b0010);
    c = '0; c.asa = 1'b1; c.asb = 2'b10;
    cycle(c, 3'd2, 1'b1, 1'b0, 4'b0010);
    c = '0; c.iord = 1'b1; c.mr = 1'b1;
    cycle(c, 3'd3, 1'b0, 1'b0, 4'b0010);
    MemReady = 1'b0; Halt = 1'b0;
    #2;
    Reset = 1'b1;
    #1;
    chk("midrst_state", 32'(State), 32'd0);
    chk("midrst_mr", 32'(MemRead), 32'd0);
    chk("midrst_rw", 32'(RegWrite), 32'd0);
    chk("midrst_count", 32'(RetiredCount), 32'd0);
    MemReady = 1'b1;
    @(negedge Clock);
    chk("midrst_mr_held", 32'(MemRead), 32'd0);
    chk("midrst_rw_held", 32'(RegWrite), 32'd0);
    chk("midrst_irw_held", 32'(IRWrite), 32'd0);
    @(posedge Clock);
    #1;
    chk("midrst_state_held", 32'(State), 32'd0);
    MemReady = 1'b0;
    @(negedge Clock);
    Reset = 1'b0;
    cntModel = 0;
    #1;
    chk("post_rst_state", 32'(State), 32'd0);
    chk("post_rst_mr", 32'(MemRead), 32'd1);
    @(posedge Clock);
    #1;
    $display("reset mid-MEM done");

    // Randomized instruction stream.
    for (int i = 0; i < 200; i++) begin
      if (i % 25 == 24) doReset();
      if ($urandom_range(0, 4) == 0) begin
        do op = r4(); while (isLegal(op));
      end else begin
        op = LEGAL[$urandom_range(0, 5)];
      end
      runInstr(op, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
               ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : 0, n);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
